vend_controller: RTL and testbench

- Transaction sequencer for the vending datapath.
- Accumulates inserted coins into a credit register and checks a product selection against a price table.
- Drives a dispense handshake to the product dispenser, then pays out change one coin at a time over a ready/valid coin-return interface.
- Also handles cancel and inactivity timeout by refunding the full credit.

---
 rtl/vend_controller_if.sv | 36 +++
 rtl/vend_controller.sv | 171 +++++++++++++++++
 tb/tb_vend_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_controller_if.sv
// Bus between the vending transaction sequencer and its surroundings:
// coin slot, selection keypad, dispenser handshake, coin-return hopper
// and status flags.
interface vend_controller_if;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       sel_valid;
  logic [2:0] sel_product;
  logic       cancel;
  logic       vend_req;
  logic       vend_ack;
  logic       coin_out_valid;
  logic [7:0] coin_out_value;
  logic       coin_out_ready;
  logic [7:0] credit;
  logic [7:0] change;
  logic       trans_success;
  logic       coin_reject;
  logic       no_funds;

  // Controller side
  modport master (
    input  coin_valid, coin_value, sel_valid, sel_product, cancel,
    input  vend_ack, coin_out_ready,
    output vend_req, coin_out_valid, coin_out_value,
    output credit, change, trans_success, coin_reject, no_funds
  );

  // Environment side (coin slot, keypad, dispenser, hopper)
  modport slave (
    output coin_valid, coin_value, sel_valid, sel_product, cancel,
    output vend_ack, coin_out_ready,
    input  vend_req, coin_out_valid, coin_out_value,
    input  credit, change, trans_success, coin_reject, no_funds
  );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction sequencer: collects coins into a credit register,
// checks selections against the price table, handshakes with the
// dispenser and pays change back one coin per accepted transfer.
// Cancel and inactivity timeout refund the whole credit.
module vend_controller #(
  parameter int PRICE1     = 10,
  parameter int PRICE2     = 20,
  parameter int PRICE3     = 50,
  parameter int PRICE4     = 100,
  parameter int MAX_CREDIT = 200,
  parameter int TIMEOUT    = 1000,
  parameter int TIMER_W    = 16
) (
  input logic               clock,
  input logic               reset,
  vend_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         credit_r;
  logic [7:0]         change_r;
  logic [7:0]         coin_out_value_r;
  logic               coin_out_valid_r;
  logic               vend_req_r;
  logic               trans_success_r;
  logic               coin_reject_r;
  logic               no_funds_r;

  function automatic logic [7:0] price_of(input logic [2:0] product);
    logic [7:0] p;
    p = 8'd0;
    case (product)
      3'd1:    p = 8'(PRICE1);
      3'd2:    p = 8'(PRICE2);
      3'd3:    p = 8'(PRICE3);
      3'd4:    p = 8'(PRICE4);
      default: p = 8'd0;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] largest_coin(input logic [7:0] amount);
    logic [7:0] c;
    if (amount >= 8'd100)     c = 8'd100;
    else if (amount >= 8'd50) c = 8'd50;
    else if (amount >= 8'd20) c = 8'd20;
    else if (amount >= 8'd10) c = 8'd10;
    else                      c = 8'd0;
    return c;
  endfunction

  logic       sel_legal;
  logic [7:0] sel_price;
  logic [8:0] coin_sum;
  logic       coin_ok;
  logic       timeout_hit;
  logic [7:0] credit_after_coin;

  // Decode of this cycle's inputs; the coin sum is 9 bits so overflow past 255 is still caught
  assign sel_legal = bus.sel_valid && (bus.sel_product != 3'd0) && (bus.sel_product <= 3'd4);
  assign sel_price = price_of(bus.sel_product);
  assign coin_sum  = {1'b0, credit_r} + {1'b0, bus.coin_value};
  assign coin_ok   = bus.coin_valid
                     && ((bus.coin_value == 8'd10) || (bus.coin_value == 8'd20) ||
                         (bus.coin_value == 8'd50) || (bus.coin_value == 8'd100))
                     && (coin_sum <= 9'(MAX_CREDIT));
  assign timeout_hit       = (timer == TIMER_W'(TIMEOUT - 1)) && !sel_legal && !coin_ok;
  assign credit_after_coin = credit_r - coin_out_value_r;

  // Transaction state machine with all outputs registered
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      timer            <= '0;
      credit_r         <= 8'd0;
      change_r         <= 8'd0;
      coin_out_value_r <= 8'd0;
      coin_out_valid_r <= 1'b0;
      vend_req_r       <= 1'b0;
      trans_success_r  <= 1'b0;
      coin_reject_r    <= 1'b0;
      no_funds_r       <= 1'b0;
    end else begin
      trans_success_r <= 1'b0;
      coin_reject_r   <= 1'b0;
      no_funds_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_legal) begin
            no_funds_r    <= 1'b1;
            coin_reject_r <= bus.coin_valid;
          end else if (coin_ok) begin
            credit_r <= coin_sum[7:0];
            timer    <= '0;
            state    <= COLLECT;
          end else begin
            coin_reject_r <= bus.coin_valid;
          end
        end
        COLLECT: begin
          if (bus.cancel || timeout_hit) begin
            change_r         <= credit_r;
            coin_out_valid_r <= 1'b1;
            coin_out_value_r <= largest_coin(credit_r);
            timer            <= '0;
            coin_reject_r    <= bus.coin_valid;
            state            <= CHANGE;
          end else if (sel_legal) begin
            coin_reject_r <= bus.coin_valid;
            timer         <= '0;
            if (credit_r >= sel_price) begin
              credit_r   <= credit_r - sel_price;
              change_r   <= credit_r - sel_price;
              vend_req_r <= 1'b1;
              state      <= VEND;
            end else begin
              no_funds_r <= 1'b1;
            end
          end else if (coin_ok) begin
            credit_r <= coin_sum[7:0];
            timer    <= '0;
          end else begin
            coin_reject_r <= bus.coin_valid;
            timer         <= timer + TIMER_W'(1);
          end
        end
        VEND: begin
          coin_reject_r <= bus.coin_valid;
          if (bus.vend_ack) begin
            vend_req_r      <= 1'b0;
            trans_success_r <= 1'b1;
            if (credit_r != 8'd0) begin
              coin_out_valid_r <= 1'b1;
              coin_out_value_r <= largest_coin(credit_r);
              state            <= CHANGE;
            end else begin
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          coin_reject_r <= bus.coin_valid;
          if (coin_out_valid_r && bus.coin_out_ready) begin
            credit_r <= credit_after_coin;
            if (credit_after_coin == 8'd0) begin
              coin_out_valid_r <= 1'b0;
              coin_out_value_r <= 8'd0;
              state            <= IDLE;
            end else begin
              coin_out_value_r <= largest_coin(credit_after_coin);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vend_req       = vend_req_r;
  assign bus.coin_out_valid = coin_out_valid_r;
  assign bus.coin_out_value = coin_out_value_r;
  assign bus.credit         = credit_r;
  assign bus.change         = change_r;
  assign bus.trans_success  = trans_success_r;
  assign bus.coin_reject    = coin_reject_r;
  assign bus.no_funds       = no_funds_r;

endmodule

// File: tb/tb_vend_controller.sv
// Testbench for vend_controller: a table of single-cycle vectors walks
// the purchase, refund, reject and change paths; hand-written sequences
// cover the inactivity timeout and a reset in the middle of paying change.
module tb_vend_controller;

  localparam int TIMEOUT = 1000;

  typedef struct packed {
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       sel_valid;
    logic [2:0] sel_product;
    logic       cancel;
    logic       vend_ack;
    logic       coin_out_ready;
    logic       rst_n;
  } in_t;

  typedef struct packed {
    logic       vend_req;
    logic       coin_out_valid;
    logic [7:0] coin_out_value;
    logic [7:0] credit;
    logic [7:0] change;
    logic       trans_success;
    logic       coin_reject;
    logic       no_funds;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[$];
  sb_t  sb_q[$];

  vend_controller_if bus ();

  vend_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic in_t mkin(input logic cv, input logic [7:0] cval, input logic sv,
                               input logic [2:0] sp, input logic cn, input logic ack,
                               input logic rdy, input logic rst_n);
    in_t s;
    s = '{coin_valid: cv, coin_value: cval, sel_valid: sv, sel_product: sp,
          cancel: cn, vend_ack: ack, coin_out_ready: rdy, rst_n: rst_n};
    return s;
  endfunction

  function automatic out_t mkout(input logic vreq, input logic ov, input logic [7:0] oval,
                                 input logic [7:0] cr, input logic [7:0] ch,
                                 input logic ts, input logic rej, input logic nf);
    out_t o;
    o = '{vend_req: vreq, coin_out_valid: ov, coin_out_value: oval, credit: cr,
          change: ch, trans_success: ts, coin_reject: rej, no_funds: nf};
    return o;
  endfunction

  function automatic in_t in_idle();
    return mkin(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic in_t in_coin(input logic [7:0] v);
    return mkin(1'b1, v, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic in_t in_sel(input logic [2:0] p);
    return mkin(1'b0, 8'd0, 1'b1, p, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic in_t in_cancel();
    return mkin(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic in_t in_ack();
    return mkin(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic in_t in_rdy();
    return mkin(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic in_t in_reset();
    return mkin(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic addVec(input string name, input in_t s, input out_t e);
    vec_t v;
    v.name = name;
    v.stim = s;
    v.exp  = e;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    reset              = v.stim.rst_n;
    bus.coin_valid     = v.stim.coin_valid;
    bus.coin_value     = v.stim.coin_value;
    bus.sel_valid      = v.stim.sel_valid;
    bus.sel_product    = v.stim.sel_product;
    bus.cancel         = v.stim.cancel;
    bus.vend_ack       = v.stim.vend_ack;
    bus.coin_out_ready = v.stim.coin_out_ready;
    e.name = v.name;
    e.exp  = v.exp;
    sb_q.push_back(e);
  endtask

  // Let the edge happen, then compare the DUT outputs with the oldest queued expectation
  task automatic checkOutput();
    sb_t  e;
    out_t act;
    @(posedge clock);
    @(negedge clock);
    act = {bus.vend_req, bus.coin_out_valid, bus.coin_out_value, bus.credit, bus.change,
           bus.trans_success, bus.coin_reject, bus.no_funds};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, required one expectation");
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got vreq=%0b ov=%0b oval=%0d credit=%0d change=%0d ts=%0b rej=%0b nf=%0b, required vreq=%0b ov=%0b oval=%0d credit=%0d change=%0d ts=%0b rej=%0b nf=%0b",
                 e.name, act.vend_req, act.coin_out_valid, act.coin_out_value, act.credit,
                 act.change, act.trans_success, act.coin_reject, act.no_funds,
                 e.exp.vend_req, e.exp.coin_out_valid, e.exp.coin_out_value, e.exp.credit,
                 e.exp.change, e.exp.trans_success, e.exp.coin_reject, e.exp.no_funds);
      end
    end
  endtask

  task automatic run(input string name, input in_t s, input out_t e);
    vec_t v;
    v.name = name;
    v.stim = s;
    v.exp  = e;
    applyStimulus(v);
    checkOutput();
  endtask

  // Main test sequence
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_value = 8'd0; bus.sel_valid = 1'b0;
    bus.sel_product = 3'd0; bus.cancel = 1'b0; bus.vend_ack = 1'b0;
    bus.coin_out_ready = 1'b0;

    // Outputs: vreq, ov, oval, credit, change, ts, rej, nf
    addVec("reset",          in_reset(),  mkout(0, 0, 8'd0,   8'd0,   8'd0,   0, 0, 0));
    addVec("buy2_coin50",    in_coin(50), mkout(0, 0, 8'd0,   8'd50,  8'd0,   0, 0, 0));
    addVec("buy2_coin20",    in_coin(20), mkout(0, 0, 8'd0,   8'd70,  8'd0,   0, 0, 0));
    addVec("buy2_sel2",      in_sel(2),   mkout(1, 0, 8'd0,   8'd50,  8'd50,  0, 0, 0));
    addVec("buy2_wait_ack",  in_idle(),   mkout(1, 0, 8'd0,   8'd50,  8'd50,  0, 0, 0));
    addVec("buy2_ack",       in_ack(),    mkout(0, 1, 8'd50,  8'd50,  8'd50,  1, 0, 0));
    addVec("buy2_coin_out",  in_rdy(),    mkout(0, 0, 8'd0,   8'd0,   8'd50,  0, 0, 0));
    addVec("buy2_idle",      in_idle(),   mkout(0, 0, 8'd0,   8'd0,   8'd50,  0, 0, 0));
    addVec("buy3_coin100a",  in_coin(100),mkout(0, 0, 8'd0,   8'd100, 8'd50,  0, 0, 0));
    addVec("buy3_coin100b",  in_coin(100),mkout(0, 0, 8'd0,   8'd200, 8'd50,  0, 0, 0));
    addVec("buy3_sel3",      in_sel(3),   mkout(1, 0, 8'd0,   8'd150, 8'd150, 0, 0, 0));
    addVec("buy3_ack",       in_ack(),    mkout(0, 1, 8'd100, 8'd150, 8'd150, 1, 0, 0));
    for (int k = 0; k < 5; k++)
      addVec("buy3_stall",   in_idle(),   mkout(0, 1, 8'd100, 8'd150, 8'd150, 0, 0, 0));
    addVec("buy3_out100",    in_rdy(),    mkout(0, 1, 8'd50,  8'd50,  8'd150, 0, 0, 0));
    addVec("buy3_out50",     in_rdy(),    mkout(0, 0, 8'd0,   8'd0,   8'd150, 0, 0, 0));
    addVec("nf_coin20",      in_coin(20), mkout(0, 0, 8'd0,   8'd20,  8'd150, 0, 0, 0));
    addVec("nf_sel4",        in_sel(4),   mkout(0, 0, 8'd0,   8'd20,  8'd150, 0, 0, 1));
    addVec("nf_cancel",      in_cancel(), mkout(0, 1, 8'd20,  8'd20,  8'd20,  0, 0, 0));
    addVec("nf_refund20",    in_rdy(),    mkout(0, 0, 8'd0,   8'd0,   8'd20,  0, 0, 0));
    addVec("nf_idle",        in_idle(),   mkout(0, 0, 8'd0,   8'd0,   8'd20,  0, 0, 0));
    addVec("rej_coin30",     in_coin(30), mkout(0, 0, 8'd0,   8'd0,   8'd20,  0, 1, 0));
    addVec("rej_coin100",    in_coin(100),mkout(0, 0, 8'd0,   8'd100, 8'd20,  0, 0, 0));
    addVec("rej_coin50",     in_coin(50), mkout(0, 0, 8'd0,   8'd150, 8'd20,  0, 0, 0));
    addVec("rej_overflow",   in_coin(100),mkout(0, 0, 8'd0,   8'd150, 8'd20,  0, 1, 0));
    addVec("rej_sel1",       in_sel(1),   mkout(1, 0, 8'd0,   8'd140, 8'd140, 0, 0, 0));
    addVec("rej_coin_vend",  in_coin(10), mkout(1, 0, 8'd0,   8'd140, 8'd140, 0, 1, 0));
    addVec("rej_ack_cancel", mkin(0, 8'd0, 0, 3'd0, 1, 1, 0, 1),
                                          mkout(0, 1, 8'd100, 8'd140, 8'd140, 1, 0, 0));
    addVec("rej_out100",     in_rdy(),    mkout(0, 1, 8'd20,  8'd40,  8'd140, 0, 0, 0));
    addVec("rej_out20a",     in_rdy(),    mkout(0, 1, 8'd20,  8'd20,  8'd140, 0, 0, 0));
    addVec("rej_out20b",     in_rdy(),    mkout(0, 0, 8'd0,   8'd0,   8'd140, 0, 0, 0));
    addVec("pri_coin20a",    in_coin(20), mkout(0, 0, 8'd0,   8'd20,  8'd140, 0, 0, 0));
    addVec("pri_coin20b",    in_coin(20), mkout(0, 0, 8'd0,   8'd40,  8'd140, 0, 0, 0));
    addVec("pri_all_three",  mkin(1, 8'd10, 1, 3'd1, 1, 0, 0, 1),
                                          mkout(0, 1, 8'd20,  8'd40,  8'd40,  0, 1, 0));
    addVec("pri_out20a",     in_rdy(),    mkout(0, 1, 8'd20,  8'd20,  8'd40,  0, 0, 0));
    addVec("pri_out20b",     in_rdy(),    mkout(0, 0, 8'd0,   8'd0,   8'd40,  0, 0, 0));
    addVec("idle_sel1",      in_sel(1),   mkout(0, 0, 8'd0,   8'd0,   8'd40,  0, 0, 1));
    addVec("idle_cancel",    in_cancel(), mkout(0, 0, 8'd0,   8'd0,   8'd40,  0, 0, 0));
    addVec("exact_coin10",   in_coin(10), mkout(0, 0, 8'd0,   8'd10,  8'd40,  0, 0, 0));
    addVec("exact_sel1",     in_sel(1),   mkout(1, 0, 8'd0,   8'd0,   8'd0,   0, 0, 0));
    addVec("exact_ack",      in_ack(),    mkout(0, 0, 8'd0,   8'd0,   8'd0,   1, 0, 0));
    addVec("exact_idle",     in_idle(),   mkout(0, 0, 8'd0,   8'd0,   8'd0,   0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput();
    end

    // Inactivity: credit holds for TIMEOUT-1 idle cycles, the next one refunds
    run("to_coin10", in_coin(10), mkout(0, 0, 8'd0, 8'd10, 8'd0, 0, 0, 0));
    for (int k = 0; k < TIMEOUT - 1; k++)
      run("to_waiting", in_idle(), mkout(0, 0, 8'd0, 8'd10, 8'd0, 0, 0, 0));
    run("to_refund",  in_idle(), mkout(0, 1, 8'd10, 8'd10, 8'd10, 0, 0, 0));
    run("to_out10",   in_rdy(),  mkout(0, 0, 8'd0,  8'd0,  8'd10, 0, 0, 0));

    // Reset while change is being offered clears everything with no refund
    run("rst_coin100", in_coin(100), mkout(0, 0, 8'd0,  8'd100, 8'd10, 0, 0, 0));
    run("rst_sel3",    in_sel(3),    mkout(1, 0, 8'd0,  8'd50,  8'd50, 0, 0, 0));
    run("rst_ack",     in_ack(),     mkout(0, 1, 8'd50, 8'd50,  8'd50, 1, 0, 0));
    run("rst_pulse",   in_reset(),   mkout(0, 0, 8'd0,  8'd0,   8'd0,  0, 0, 0));
    run("rst_after",   in_idle(),    mkout(0, 0, 8'd0,  8'd0,   8'd0,  0, 0, 0));
    run("rst_coin20",  in_coin(20),  mkout(0, 0, 8'd0,  8'd20,  8'd0,  0, 0, 0));
    run("rst_cancel",  in_cancel(),  mkout(0, 1, 8'd20, 8'd20,  8'd20, 0, 0, 0));
    run("rst_out20",   in_rdy(),     mkout(0, 0, 8'd0,  8'd0,   8'd20, 0, 0, 0));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
